// File: rtl/udp_rx2fifo_if.sv
// UDP payload receive / downstream FIFO / consumer handshake bundle.
// master drives the payload stream, FIFO space and fd; slave is the streamer.
interface udp_rx2fifo_if #(
  parameter int LEN_W = 12
);
  logic             udp_rxen;
  logic [7:0]       udp_rxd;
  logic [LEN_W-1:0] udp_rx_len;
  logic [LEN_W-1:0] fifod_space;
  logic             fifod_txen;
  logic [7:0]       fifod_txd;
  logic             fs;
  logic             fd;
  logic [LEN_W-1:0] data_len;
  logic             drop;
  logic             err_len;

  modport master (
    output udp_rxen, udp_rxd, udp_rx_len,
    output fifod_space, fd,
    input  fifod_txen, fifod_txd, fs,
    input  data_len, drop, err_len
  );

  modport slave (
    input  udp_rxen, udp_rxd, udp_rx_len,
    input  fifod_space, fd,
    output fifod_txen, fifod_txd, fs,
    output data_len, drop, err_len
  );
endinterface

// File: rtl/udp_rx2fifo.sv
// UDP payload stream to downstream FIFO writer with fs/fd packet handshake.
// Define UDP_RX_STAT_EN to add pkt_ok_cnt / pkt_drop_cnt statistics outputs.
module udp_rx2fifo #(
  parameter int MAX_LEN = 1472,
  parameter int LEN_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  udp_rx2fifo_if.slave bus
`ifdef UDP_RX_STAT_EN
  ,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] pkt_drop_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, WORK, TRIM, DROP, NOTIFY, RELEASE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] exp_len;
  logic [LEN_W-1:0] cnt;
  logic             rxen_q;
  logic             bdrop;
  logic             ok;
  logic             busy;

  always_comb begin
    ok = (bus.udp_rx_len != '0)
      && (bus.udp_rx_len <= LEN_W'(MAX_LEN))
      && (bus.udp_rx_len <= bus.fifod_space);
  end

  assign busy = (state == NOTIFY) || (state == RELEASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      exp_len        <= '0;
      cnt            <= '0;
      rxen_q         <= 1'b0;
      bdrop          <= 1'b0;
      bus.fifod_txen <= 1'b0;
      bus.fifod_txd  <= '0;
      bus.fs         <= 1'b0;
      bus.data_len   <= '0;
      bus.drop       <= 1'b0;
      bus.err_len    <= 1'b0;
    end else begin
      bus.fifod_txen <= 1'b0;
      bus.drop       <= 1'b0;
      bus.err_len    <= 1'b0;
      rxen_q         <= bus.udp_rxen;
      // a packet starting while the consumer holds the buffer is discarded
      if (busy && bus.udp_rxen && !rxen_q) begin
        bdrop <= 1'b1;
      end else if (bdrop && !bus.udp_rxen) begin
        bdrop    <= 1'b0;
        bus.drop <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.udp_rxen && !bdrop) begin
            if (ok) begin
              state          <= WORK;
              exp_len        <= bus.udp_rx_len;
              cnt            <= LEN_W'(1);
              bus.fifod_txen <= 1'b1;
              bus.fifod_txd  <= bus.udp_rxd;
            end else begin
              state <= DROP;
            end
          end
        end
        WORK: begin
          if (bus.udp_rxen) begin
            if (cnt == exp_len) begin
              state <= TRIM;
            end else begin
              bus.fifod_txen <= 1'b1;
              bus.fifod_txd  <= bus.udp_rxd;
              cnt            <= cnt + 1'b1;
            end
          end else begin
            state        <= NOTIFY;
            bus.fs       <= 1'b1;
            bus.data_len <= cnt;
            bus.err_len  <= (cnt != exp_len);
          end
        end
        TRIM: begin
          if (!bus.udp_rxen) begin
            state        <= NOTIFY;
            bus.fs       <= 1'b1;
            bus.data_len <= exp_len;
            bus.err_len  <= 1'b1;
          end
        end
        DROP: begin
          if (!bus.udp_rxen) begin
            state    <= IDLE;
            bus.drop <= 1'b1;
          end
        end
        NOTIFY: begin
          if (bus.fd) begin
            state  <= RELEASE;
            bus.fs <= 1'b0;
          end
        end
        RELEASE: begin
          if (!bus.fd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UDP_RX_STAT_EN
  logic fs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_q         <= 1'b0;
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      fs_q <= bus.fs;
      if (bus.fs && !fs_q) pkt_ok_cnt <= pkt_ok_cnt + 1'b1;
      if (bus.drop) pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_rx2fifo.sv
// Randomized self-checking bench for udp_rx2fifo.
// Expected writes/lengths/pulses come from a packet-level model.
module tb_udp_rx2fifo;
  localparam int MAX_LEN = 1472;
  localparam int LEN_W   = 12;

  logic clk;
  logic rst;

  udp_rx2fifo_if #(.LEN_W(LEN_W)) bus ();

`ifdef UDP_RX_STAT_EN
  logic [15:0] ok_c;
  logic [15:0] dr_c;
`endif

  udp_rx2fifo #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef UDP_RX_STAT_EN
    ,
    .pkt_ok_cnt   (ok_c),
    .pkt_drop_cnt (dr_c)
`endif
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit [7:0] sent_b[$];
  int       sent_c[$];
  bit [7:0] got_b[$];
  int       got_c[$];
  int       n_drop;
  int       n_err;
  int       n_fs;
  logic     fs_prev = 1'b0;
  int       held_len;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.fifod_txen) begin
      got_b.push_back(bus.fifod_txd);
      got_c.push_back(cyc);
    end
    if (bus.drop) n_drop++;
    if (bus.err_len) n_err++;
    if (bus.fs && !fs_prev) begin
      n_fs++;
      held_len = int'(bus.data_len);
      chk("fs_after_wr", got_b.size(), int'(bus.data_len));
    end else if (bus.fs) begin
      chk("len_stable", int'(bus.data_len), held_len);
    end
    fs_prev = bus.fs;
  end

  task automatic clear();
    sent_b.delete();
    sent_c.delete();
    got_b.delete();
    got_c.delete();
    n_drop = 0;
    n_err  = 0;
    n_fs   = 0;
  endtask

  task automatic send(input int len, input int space, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.udp_rxen    = 1'b1;
      bus.udp_rxd     = 8'($urandom);
      bus.udp_rx_len  = (i == 0) ? LEN_W'(len) : LEN_W'($urandom);
      bus.fifod_space = (i == 0) ? LEN_W'(space) : LEN_W'($urandom);
      sent_b.push_back(bus.udp_rxd);
      sent_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    bus.udp_rxen = 1'b0;
  endtask

  task automatic release_pkt();
    @(posedge clk);
    #1;
    bus.fd = 1'b1;
    for (int k = 0; k < 10 && bus.fs; k++) begin
      @(posedge clk);
      #1;
    end
    chk("fs_fall", bus.fs, 0);
    bus.fd = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pkt(input int len, input int space, input int n,
                     input bit hold);
    bit ok;
    int nacc;
    clear();
    ok   = (len != 0) && (len <= MAX_LEN) && (len <= space);
    nacc = ok ? ((n < len) ? n : len) : 0;
    send(len, space, n);
    if (ok) begin
      for (int k = 0; k < 20 && n_fs == 0; k++) @(posedge clk);
    end else begin
      repeat (4) @(posedge clk);
    end
    #1;
    chk("fs_seen", n_fs, ok ? 1 : 0);
    chk("wr_cnt", got_b.size(), nacc);
    for (int i = 0; i < nacc && i < got_b.size(); i++) begin
      chk("wr_data", got_b[i], sent_b[i]);
      chk("wr_cyc", got_c[i], sent_c[i] + 1);
    end
    chk("drop", n_drop, ok ? 0 : 1);
    chk("err_len", n_err, (ok && n != len) ? 1 : 0);
    if (ok && n_fs == 1) begin
      chk("data_len", int'(bus.data_len), nacc);
      if (!hold) release_pkt();
    end
  endtask

  initial begin
    int len, space, n, r;
    rst              = 1'b1;
    bus.udp_rxen     = 1'b0;
    bus.udp_rxd      = '0;
    bus.udp_rx_len   = '0;
    bus.fifod_space  = '0;
    bus.fd           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", int'({bus.fifod_txen, bus.fifod_txd, bus.fs,
                         bus.data_len, bus.drop, bus.err_len}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    pkt(4, 100, 4, 0);
    pkt(10, 9, 10, 0);
    pkt(6, 100, 3, 0);
    pkt(3, 100, 5, 0);
    pkt(1472, 4095, 3, 0);
    pkt(1473, 4095, 3, 0);
    pkt(0, 100, 2, 0);
    pkt(5, 5, 5, 0);

    pkt(4, 100, 4, 1);
    clear();
    send(2, 100, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_wr", got_b.size(), 0);
    chk("busy_drop", n_drop, 1);
    chk("busy_fs", bus.fs, 1);
    release_pkt();
    pkt(2, 100, 2, 0);

    clear();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      bus.udp_rxen    = 1'b1;
      bus.udp_rxd     = 8'($urandom);
      bus.udp_rx_len  = LEN_W'(8);
      bus.fifod_space = LEN_W'(100);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid", int'({bus.fifod_txen, bus.fifod_txd, bus.fs,
                         bus.data_len, bus.drop, bus.err_len}), 0);
    bus.udp_rxen = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt(5, 100, 5, 0);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = 0;
      else if (r == 1) len = 1473 + $urandom_range(0, 99);
      else len = $urandom_range(1, 16);
      space = $urandom_range(0, 20);
      n     = $urandom_range(1, 20);
      pkt(len, space, n, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
